// File: rtl/hcube_route_unit_pkg.sv
// Shared widths and the combinational helpers used by the hypercube route unit:
// Hamming(7,4) syndrome/correction and dimension-order port selection.
package noc_route_pkg;

    localparam int PAYLOAD_W = 7;
    localparam int MAX_DIM   = 16;

    function automatic logic [2:0] ham_syndrome(input logic [PAYLOAD_W-1:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[2] ^ d[4] ^ d[6];
        p2 = d[1] ^ d[2] ^ d[5] ^ d[6];
        p4 = d[3] ^ d[4] ^ d[5] ^ d[6];
        return {p4, p2, p1};
    endfunction

    // A non-zero syndrome names the 1-based position of the flipped bit.
    function automatic logic [PAYLOAD_W-1:0] ham_correct(input logic [PAYLOAD_W-1:0] d);
        logic [2:0]           syn;
        logic [PAYLOAD_W-1:0] c;
        syn = ham_syndrome(d);
        c   = d;
        for (int i = 0; i < PAYLOAD_W; i++) begin
            if (syn == 3'(i + 1)) c[i] = ~d[i];
        end
        return c;
    endfunction

    // Returns dim when x is zero (local core), else lowest or highest set bit.
    function automatic int route_sel(input logic [MAX_DIM-1:0] x, input logic msb_first,
                                     input int dim);
        int sel;
        sel = dim;
        if (msb_first) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                if (i < dim && x[i]) sel = i;
            end
        end else begin
            for (int i = MAX_DIM - 1; i >= 0; i--) begin
                if (i < dim && x[i]) sel = i;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hcube_route_unit_if.sv
// Flit input stream plus the one-hot multi-port output stream of a router input.
interface hcube_route_unit_if
    import noc_route_pkg::*;
#(
    parameter int DIM = 4
);
    localparam int FLIT_W = PAYLOAD_W + DIM;

    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] in_flit;
    logic [DIM:0]      out_valid;
    logic [DIM:0]      out_ready;
    logic [FLIT_W-1:0] out_flit;

    modport master (
        output in_valid, in_flit, out_ready,
        input  in_ready, out_valid, out_flit
    );

    modport slave (
        input  in_valid, in_flit, out_ready,
        output in_ready, out_valid, out_flit
    );
endinterface

// File: rtl/hcube_route_unit_route_fifo.sv
// Power-of-two circular FIFO with a first-word-fall-through read port.
module route_fifo
    import noc_route_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hcube_route_unit.sv
// Router input stage: FIFO, Hamming correction and dimension-order route on the
// head flit, one-hot presentation register and a saturating corrected-flit count.
module hcube_route_unit
    import noc_route_pkg::*;
#(
    parameter int             DIM        = 4,
    parameter logic [DIM-1:0] NODE_ADDR  = '0,
    parameter int             FIFO_DEPTH = 4,
    parameter bit             MSB_FIRST  = 1'b0,
    parameter int             CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    hcube_route_unit_if.slave  bus,
    input  logic               corr_clr,
    output logic [CNT_W-1:0]   corr_cnt
);
    localparam int FLIT_W = PAYLOAD_W + DIM;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int PORTS  = DIM + 1;
    localparam int IDX_W  = $clog2(PORTS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              in_ready_q;
    logic              push_p0;
    logic              load_p0;
    logic              full_p0;
    logic              empty_p0;
    logic [CW-1:0]     count_p0;
    logic [CW-1:0]     count_nxt;
    logic [FLIT_W-1:0] head_p0;
    logic [2:0]        syn_p0;
    logic [FLIT_W-1:0] fix_p0;
    logic [DIM-1:0]    x_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [DIM:0]      oh_p0;
    logic [DIM:0]      oh_p1;
    logic [FLIT_W-1:0] flit_p1;
    logic              vld_p1;
    logic              retire_p1;

    assign push_p0 = bus.in_valid && in_ready_q && !full_p0;

    route_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_p0),
        .pop   (load_p0),
        .wdata (bus.in_flit),
        .rdata (head_p0),
        .full  (full_p0),
        .empty (empty_p0),
        .count (count_p0)
    );

    // p0: correction and routing computed on the FIFO head
    assign syn_p0 = ham_syndrome(head_p0[FLIT_W-1 -: PAYLOAD_W]);
    assign fix_p0 = {ham_correct(head_p0[FLIT_W-1 -: PAYLOAD_W]), head_p0[DIM-1:0]};
    assign x_p0   = head_p0[DIM-1:0] ^ NODE_ADDR;
    assign idx_p0 = IDX_W'(route_sel(MAX_DIM'(x_p0), MSB_FIRST, DIM));
    assign oh_p0  = PORTS'(1) << idx_p0;

    assign vld_p1    = |oh_p1;
    assign retire_p1 = |(oh_p1 & bus.out_ready);
    assign load_p0   = !empty_p0 && (!vld_p1 || retire_p1);
    assign count_nxt = count_p0 + CW'(push_p0) - CW'(load_p0);

    // in_ready follows the post-edge occupancy so it never depends on same-cycle pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_q <= 1'b0;
        else        in_ready_q <= (count_nxt < CW'(FIFO_DEPTH));
    end

    // p1: presentation register, held until one selected sink accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oh_p1   <= '0;
            flit_p1 <= '0;
        end else if (load_p0) begin
            oh_p1   <= oh_p0;
            flit_p1 <= fix_p0;
        end else if (retire_p1) begin
            oh_p1   <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          corr_cnt <= '0;
        else if (corr_clr)                   corr_cnt <= '0;
        else if (load_p0 && syn_p0 != 3'd0)  corr_cnt <= sat_inc(corr_cnt);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = oh_p1;
    assign bus.out_flit  = flit_p1;

endmodule

// File: tb/tb_hcube_route_unit.sv
// Scoreboard bench: two route units (lowest-bit/8-bit counter and highest-bit/
// 2-bit counter) see identical flits; a monitor checks every retired flit.
module tb_hcube_route_unit;
    localparam int DIM = 4;
    localparam int FW  = 7 + DIM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic corr_clr = 1'b0;
    logic in_valid = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic [DIM:0] rdy_a = '0;
    logic [DIM:0] rdy_b = '0;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    hcube_route_unit_if #(.DIM(DIM)) ifa ();
    hcube_route_unit_if #(.DIM(DIM)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_flit   = in_flit;
    assign ifa.out_ready = rdy_a;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_flit   = in_flit;
    assign ifb.out_ready = rdy_b;

    hcube_route_unit #(.DIM(DIM), .NODE_ADDR(4'b0000), .FIFO_DEPTH(4),
                       .MSB_FIRST(1'b0), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .corr_clr(corr_clr), .corr_cnt(cnt_a));

    hcube_route_unit #(.DIM(DIM), .NODE_ADDR(4'b0000), .FIFO_DEPTH(4),
                       .MSB_FIRST(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .corr_clr(corr_clr), .corr_cnt(cnt_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] flit;
        logic [DIM:0]  oh;
        int            cnt;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int checks = 0;
    int errors = 0;
    int sb_a = 0;
    int sb_b = 0;
    int rdy_mode = 0;
    logic          pv [2];
    logic          pr [2];
    logic [FW-1:0] pf [2];
    logic [DIM:0]  po [2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Syndrome as XOR of the 1-based positions of all set payload bits.
    function automatic int mdl_syn(input logic [FW-1:0] f);
        int s = 0;
        for (int i = 0; i < 7; i++) if (f[DIM + i]) s = s ^ (i + 1);
        return s;
    endfunction

    function automatic logic [FW-1:0] mdl_flit(input logic [FW-1:0] f);
        logic [FW-1:0] r = f;
        int s = mdl_syn(f);
        if (s != 0) r[DIM + s - 1] = ~r[DIM + s - 1];
        return r;
    endfunction

    function automatic logic [DIM:0] mdl_dest(input logic [DIM-1:0] addr, input bit msb);
        logic [DIM-1:0] x = addr ^ 4'b0000;
        logic [DIM:0]   oh = '0;
        int pick = DIM;
        for (int i = 0; i < DIM; i++) begin
            if (x[i] && (msb || pick == DIM)) pick = i;
        end
        oh[pick] = 1'b1;
        return oh;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Called at posedge+1; waits for both units to be ready, then offers one flit.
    task automatic push(input logic [FW-1:0] f, input bit clr_on_load);
        int n = 0;
        ent_t e;
        bit err;
        while (!(ifa.in_ready && ifb.in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready a=%0b b=%0b required 1", ifa.in_ready, ifb.in_ready);
            return;
        end
        err  = (mdl_syn(f) != 0);
        sb_a = clr_on_load ? 0 : sat(sb_a + int'(err), 255);
        sb_b = clr_on_load ? 0 : sat(sb_b + int'(err), 3);
        e.flit = mdl_flit(f); e.oh = mdl_dest(f[DIM-1:0], 1'b0); e.cnt = sb_a; qa.push_back(e);
        e.oh = mdl_dest(f[DIM-1:0], 1'b1); e.cnt = sb_b; qb.push_back(e);
        in_flit  = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit, output int n);
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending a=%0d b=%0d required 0", qa.size(), qb.size());
        end
    endtask

    function automatic logic [FW-1:0] err_flit();
        logic [FW-1:0] f;
        do f = FW'($urandom); while (mdl_syn(f) == 0);
        return f;
    endfunction

    task automatic mon(input int id, input logic [DIM:0] ov, input logic [DIM:0] rdy,
                       input logic [FW-1:0] of, input int cnt);
        ent_t e;
        bit ret;
        bit have;
        if (pv[id] && !pr[id]) begin
            chk($sformatf("hold_valid%0d", id), 32'(ov), 32'(po[id]));
            if (ov != '0) chk($sformatf("hold_flit%0d", id), 32'(of), 32'(pf[id]));
        end
        ret = ((ov & rdy) != '0);
        if (ov != '0) begin
            chk($sformatf("onehot%0d", id), 32'($onehot(ov)), 32'd1);
            if (ret) begin
                have = (id == 0) ? (qa.size() != 0) : (qb.size() != 0);
                if (!have) begin
                    checks++; errors++;
                    $display("FAIL unexpected_flit%0d: got %0h with valid %0b required none", id, of, ov);
                end else begin
                    if (id == 0) e = qa.pop_front();
                    else         e = qb.pop_front();
                    chk($sformatf("flit%0d", id), 32'(of), 32'(e.flit));
                    chk($sformatf("dest%0d", id), 32'(ov), 32'(e.oh));
                    chk($sformatf("corr_cnt%0d", id), 32'(cnt), 32'(e.cnt));
                end
            end
        end
        pv[id] = (ov != '0);
        pr[id] = ret;
        pf[id] = of;
        po[id] = ov;
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon(0, ifa.out_valid, rdy_a, ifa.out_flit, int'(cnt_a));
                mon(1, ifb.out_valid, rdy_b, ifb.out_flit, int'(cnt_b));
            end else begin
                pv[0] = 1'b0; pv[1] = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       begin rdy_a = '1; rdy_b = '1; end
                1:       begin rdy_a = '0; rdy_b = '0; end
                default: begin rdy_a = (DIM+1)'($urandom); rdy_b = (DIM+1)'($urandom); end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid_a", 32'(ifa.out_valid), 0);
        chk("rst_out_valid_b", 32'(ifb.out_valid), 0);
        chk("rst_out_flit", 32'(ifa.out_flit), 0);
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_in_ready", 32'(ifa.in_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 32'(ifa.in_ready), 0);
        @(posedge clk); #1;
        chk("in_ready_after_rst", 32'(ifa.in_ready), 1);

        // Clean route with first-flit latency.
        rdy_mode = 0;
        push({7'b0000000, 4'b0100}, 1'b0);
        chk("lat_early", 32'(ifa.out_valid), 0);
        @(posedge clk); #1;
        chk("lat_valid_a", 32'(ifa.out_valid), 32'b00100);
        chk("lat_valid_b", 32'(ifb.out_valid), 32'b00100);
        chk("lat_flit", 32'(ifa.out_flit), 32'({7'b0000000, 4'b0100}));
        repeat (2) @(posedge clk);
        #1;
        chk("clean_cnt", 32'(cnt_a), 0);

        // Single-bit correction, then core and split-route deliveries.
        push({7'b0000100, 4'b0001}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("corr_cnt_one", 32'(cnt_a), 1);
        push({7'b0000000, 4'b0000}, 1'b0);
        push({7'b0000000, 4'b1010}, 1'b0);
        wait_drain(50, n);

        // Backpressure until full, then drain at one flit per cycle.
        rdy_mode = 1;
        @(posedge clk); #1;
        repeat (5) push(FW'($urandom), 1'b0);
        chk("full_in_ready_a", 32'(ifa.in_ready), 0);
        chk("full_in_ready_b", 32'(ifb.in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("full_hold_ready", 32'(ifa.in_ready), 0);
        chk("full_head_valid", 32'(ifa.out_valid), 32'(qa[0].oh));
        rdy_mode = 0;
        wait_drain(50, n);
        chk("drain_cycles", 32'(n), 5);

        // Saturation of the 2-bit counter.
        repeat (5) push(err_flit(), 1'b0);
        wait_drain(50, n);
        chk("sat_cnt_b", 32'(cnt_b), 3);
        chk("cnt_a_after_sat", 32'(cnt_a), 32'(sb_a));

        // Clear coinciding with an erroneous load.
        push(err_flit(), 1'b1);
        corr_clr = 1'b1;
        @(posedge clk); #1;
        corr_clr = 1'b0;
        chk("clr_cnt_a", 32'(cnt_a), 0);
        chk("clr_cnt_b", 32'(cnt_b), 0);
        wait_drain(50, n);

        // Random traffic with random per-port readiness.
        rdy_mode = 2;
        repeat (150) begin
            push(FW'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_drain(2000, n);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Asynchronous reset with flits buffered.
        rdy_mode = 1;
        @(posedge clk); #1;
        repeat (3) push(FW'($urandom), 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_a", 32'(ifa.out_valid), 0);
        chk("mid_rst_valid_b", 32'(ifb.out_valid), 0);
        chk("mid_rst_cnt_a", 32'(cnt_a), 0);
        chk("mid_rst_in_ready", 32'(ifa.in_ready), 0);
        qa.delete();
        qb.delete();
        sb_a = 0;
        sb_b = 0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(ifa.in_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_a", 32'(ifa.out_valid), 0);
        chk("no_stale_b", 32'(ifb.out_valid), 0);
        push({7'b0000100, 4'b1000}, 1'b0);
        wait_drain(50, n);

        chk("left_a", 32'(qa.size()), 0);
        chk("left_b", 32'(qb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
